// File: rtl/regfile_read_mux.sv
// Registered two-port register-file read network.
// Each port picks one WIDTH-bit entry from the flattened array, with
// out-of-range detection, an optional hard-wired zero register and
// same-cycle write forwarding. One cycle of latency, stall holds everything.
module regfile_read_mux #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_EN  = 1'b1,
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DEPTH*WIDTH-1:0]  in,
  input  logic                    rd_en,
  input  logic                    stall,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data_a,
  output logic [WIDTH-1:0]        rd_data_b,
  output logic                    rd_valid,
  output logic                    addr_err
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  // Addresses past the last entry only exist when DEPTH is not a power of two;
  // the extra top bit keeps the compare meaningful for every DEPTH.
  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} >= DEPTH_EXT);
  endfunction

  // Returns {error, data} for one port. Priority: out-of-range, zero
  // register, forwarding, then the array entry.
  function automatic logic [WIDTH:0] select_entry(
    input logic [ADDR_W-1:0]      addr,
    input logic [DEPTH*WIDTH-1:0] arr,
    input logic                   we,
    input logic [ADDR_W-1:0]      wa,
    input logic [WIDTH-1:0]       wd
  );
    logic [WIDTH-1:0] ent;
    ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) ent = arr[i*WIDTH +: WIDTH];
    end
    if (addr_oob(addr))                  return {1'b1, {WIDTH{1'b0}}};
    if (ZERO_EN && (addr == ZERO_ADDR))  return {1'b0, {WIDTH{1'b0}}};
    if (we && (wa == addr))              return {1'b0, wd};
    return {1'b0, ent};
  endfunction

  logic [WIDTH:0]   sel_a_p0;
  logic [WIDTH:0]   sel_b_p0;
  logic [WIDTH-1:0] data_a_p1;
  logic [WIDTH-1:0] data_b_p1;
  logic             err_p1;
  logic             vld_p1;

  // ---- stage p0: combinational per-port selection ----
  // Decode, mux and forward for both ports in parallel.
  always_comb begin
    sel_a_p0 = select_entry(rd_addr_a, in, wr_en, wr_addr, wr_data);
    sel_b_p0 = select_entry(rd_addr_b, in, wr_en, wr_addr, wr_data);
  end

  // ---- stage p1: output registers ----
  // Capture on non-stalled edges; data and error only move on a read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      err_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        data_a_p1 <= sel_a_p0[WIDTH-1:0];
        data_b_p1 <= sel_b_p0[WIDTH-1:0];
        err_p1    <= sel_a_p0[WIDTH] | sel_b_p0[WIDTH];
      end
    end
  end

  assign rd_data_a = data_a_p1;
  assign rd_data_b = data_b_p1;
  assign rd_valid  = vld_p1;
  assign addr_err  = err_p1;

endmodule

// File: tb/tb_regfile_read_mux.sv
// Bench for regfile_read_mux: three instances (default, no zero register,
// DEPTH=24) share one stimulus and are compared against a behavioural model.
module tb_regfile_read_mux;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [63:0]     regs [32];
  logic [32*64-1:0] in_flat;
  logic            rd_en = 1'b0;
  logic            stall = 1'b0;
  logic [4:0]      rd_addr_a = '0;
  logic [4:0]      rd_addr_b = '0;
  logic            wr_en = 1'b0;
  logic [4:0]      wr_addr = '0;
  logic [63:0]     wr_data = '0;

  logic [63:0] o_da [3];
  logic [63:0] o_db [3];
  logic        o_vld [3];
  logic        o_err [3];

  logic [63:0] e_da [3];
  logic [63:0] e_db [3];
  logic        e_vld [3];
  logic        e_err [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_flat = '0;
    for (int i = 0; i < 32; i++) in_flat[i*64 +: 64] = regs[i];
  end

  regfile_read_mux #(.WIDTH(64), .DEPTH(32), .ZERO_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in(in_flat), .rd_en(rd_en), .stall(stall),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_data_a(o_da[0]),
    .rd_data_b(o_db[0]), .rd_valid(o_vld[0]), .addr_err(o_err[0]));

  regfile_read_mux #(.WIDTH(64), .DEPTH(32), .ZERO_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in(in_flat), .rd_en(rd_en), .stall(stall),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_data_a(o_da[1]),
    .rd_data_b(o_db[1]), .rd_valid(o_vld[1]), .addr_err(o_err[1]));

  regfile_read_mux #(.WIDTH(64), .DEPTH(24), .ZERO_EN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in(in_flat[24*64-1:0]), .rd_en(rd_en),
    .stall(stall), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data_a(o_da[2]), .rd_data_b(o_db[2]), .rd_valid(o_vld[2]),
    .addr_err(o_err[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What a read of addr returns on instance k right now: {error, data}.
  function automatic logic [64:0] ref_sel(input int addr, input int k);
    int  depth;
    bit  zen;
    depth = (k == 2) ? 24 : 32;
    zen   = (k != 1);
    if (addr >= depth)                          return {1'b1, 64'h0};
    if (zen && addr == depth - 1)               return {1'b0, 64'h0};
    if (wr_en && int'(wr_addr) == addr)         return {1'b0, wr_data};
    return {1'b0, regs[addr]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      e_da[k] = '0; e_db[k] = '0; e_vld[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("da%0d", k),  o_da[k],  e_da[k]);
      chk($sformatf("db%0d", k),  o_db[k],  e_db[k]);
      chk($sformatf("vld%0d", k), o_vld[k], e_vld[k]);
      chk($sformatf("err%0d", k), o_err[k], e_err[k]);
    end
  endtask

  // One clock edge: update the model from the inputs seen at the edge,
  // then compare 1 time unit later.
  task automatic step();
    logic [64:0] ra, rb;
    @(posedge clk);
    if (!reset && !stall) begin
      for (int k = 0; k < 3; k++) begin
        e_vld[k] = rd_en;
        if (rd_en) begin
          ra = ref_sel(int'(rd_addr_a), k);
          rb = ref_sel(int'(rd_addr_b), k);
          e_da[k]  = ra[63:0];
          e_db[k]  = rb[63:0];
          e_err[k] = ra[64] | rb[64];
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    model_clear();

    // Asynchronous reset between edges clears outputs at once.
    #2 reset = 1'b1;
    #1;
    chk("rst_da", o_da[0], 64'h0);
    chk("rst_db", o_db[0], 64'h0);
    chk("rst_vld", o_vld[0], 64'h0);
    chk("rst_err", o_err[0], 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic read.
    regs[5] = 64'hDEAD_BEEF; regs[9] = 64'h1234;
    rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    step();
    chk("basic_a", o_da[0], 64'hDEAD_BEEF);
    chk("basic_b", o_db[0], 64'h1234);
    chk("basic_vld", o_vld[0], 64'h1);

    // Zero register wins over forwarding; without it, forwarding applies.
    regs[31] = 64'hFFFF; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hAAAA;
    rd_addr_a = 5'd31;
    step();
    chk("xzr_on", o_da[0], 64'h0);
    chk("xzr_off", o_da[1], 64'hAAAA);

    // Forwarding on both ports, then a write elsewhere.
    regs[3] = 64'h11; wr_addr = 5'd3; wr_data = 64'h77;
    rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    step();
    chk("fwd_a", o_da[0], 64'h77);
    chk("fwd_b", o_db[0], 64'h77);
    wr_addr = 5'd4;
    step();
    chk("nofwd_a", o_da[0], 64'h11);
    chk("nofwd_b", o_db[0], 64'h11);

    // Stall holds everything, a request during stall is dropped.
    wr_en = 1'b0; regs[7] = 64'h55; rd_addr_a = 5'd7;
    step();
    chk("cap55", o_da[0], 64'h55);
    stall = 1'b1; rd_addr_a = 5'd9; regs[7] = 64'h99;
    repeat (3) begin
      step();
      chk("stall_a", o_da[0], 64'h55);
      chk("stall_vld", o_vld[0], 64'h1);
    end
    stall = 1'b0; rd_en = 1'b0;
    step();
    chk("unstall_vld", o_vld[0], 64'h0);
    chk("unstall_a", o_da[0], 64'h55);

    // Out of range on the DEPTH=24 instance.
    rd_en = 1'b1; rd_addr_a = 5'd2; rd_addr_b = 5'd27;
    step();
    chk("oob_b", o_db[2], 64'h0);
    chk("oob_err", o_err[2], 64'h1);
    rd_addr_b = 5'd4;
    step();
    chk("inrange_err", o_err[2], 64'h0);

    // Reset in the middle of a read: pending capture is lost.
    rd_addr_a = 5'd5;
    step();
    rd_addr_a = 5'd9;
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("midrst_a", o_da[0], 64'h0);
    chk("midrst_vld", o_vld[0], 64'h0);
    #2 reset = 1'b0;
    rd_en = 1'b0;
    step();
    chk("postrst_vld", o_vld[0], 64'h0);
    chk("postrst_a", o_da[0], 64'h0);

    // Randomised traffic.
    for (int n = 0; n < 1000; n++) begin
      regs[$urandom_range(0, 31)] = {$urandom, $urandom};
      rd_en     = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = ($urandom_range(0, 1) == 1) ? rd_addr_a : 5'($urandom_range(0, 31));
      wr_data   = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_read_mux.md
# regfile_read_mux

Parametrised, registered two-port read network for the register file: selects one WIDTH-bit entry of DEPTH per port from the flattened register array, with same-cycle write-forwarding and an optional hard-wired zero register (XZR). It sits between the register array and the ID/EX pipeline register. It adds fixed 1-cycle latency, pipeline stall hold and out-of-range detection.

## Interface
Parameters:
- WIDTH, 64, bits per register entry
- DEPTH, 32, number of entries; any value from 2 to 256
- ADDR_W, $clog2(DEPTH), address width
- ZERO_EN, 1, when 1 entry ZERO_REG always reads 0
- ZERO_REG, DEPTH-1, index of the hard-wired zero entry

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  DEPTH*WIDTH  flattened register array; entry i is in[i*WIDTH +: WIDTH]
- rd_en  input  1  read request for both ports this cycle
- stall  input  1  hold all outputs and state
- rd_addr_a  input  ADDR_W  port A address
- rd_addr_b  input  ADDR_W  port B address
- wr_en  input  1  register-file write occurring this cycle
- wr_addr  input  ADDR_W  write address (forwarding source)
- wr_data  input  WIDTH  write data (forwarding source)
- rd_data_a  output  WIDTH  registered port A result
- rd_data_b  output  WIDTH  registered port B result
- rd_valid  output  1  rd_data_a/b hold the result of a read request
- addr_err  output  1  the last captured read had an address >= DEPTH on either port

## Operation
- Per-port selection, evaluated combinationally from the port's address. Priority, highest first:
  1. Address >= DEPTH: result 0, and the port's error bit is set.
  2. ZERO_EN=1 and address == ZERO_REG: result 0. This applies even when wr_en targets ZERO_REG.
  3. wr_en=1 and wr_addr == address: result is wr_data (forwarding).
  4. Otherwise: result is the entry in[address*WIDTH +: WIDTH].
- Capture at the clock edge when stall=0:
  - rd_valid <= rd_en.
  - If rd_en=1: rd_data_a/b <= the selected values, and addr_err <= OR of both ports' error bits.
  - If rd_en=0: rd_data_a/b and addr_err hold their previous values. Only rd_valid drops.
- stall=1: every register holds, including rd_valid. All inputs, including rd_en, are ignored for that cycle. A read request presented during stall is dropped, not queued.
- Both ports are independent. Both ports may use the same address; both then return identical data.
- Forwarding applies to both ports simultaneously when both addresses match wr_addr.
- No internal state exists beyond the output registers. No FSM is used.

## Timing
- Reset (asynchronous assert, effective immediately): rd_data_a=0, rd_data_b=0, rd_valid=0, addr_err=0.
- Reset deassertion: the first capture occurs at the first rising edge with reset=0.
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, remaining stable until the next non-stalled edge.
- Reset asserted mid-read: outputs clear at once. The pending capture is lost, and no data is presented after reset releases until a new rd_en arrives.
- stall and rd_en both high: stall wins; the outputs are unchanged.
- wr_en for the read address in the same cycle: the new wr_data is returned, not the stale `in` value.
- Writes to other addresses do not disturb the captured outputs. Outputs never change between captures.
- Back-to-back reads: one result per cycle at full throughput.
- DEPTH not a power of two: the addresses DEPTH through 2^ADDR_W-1 are out of range and follow selection rule 1.
- Critical path: address decode, then the DEPTH:1 mux, then the forward compare, then the output flop. No combinational path exists from inputs to outputs.

## Test plan
- Reset and basic read:
  - Stimulus: assert reset mid-cycle.
  - Response: all outputs are 0 immediately.
  - Stimulus: release reset, set entry 5=0xDEAD_BEEF, entry 9=0x1234, rd_en=1, addr_a=5, addr_b=9.
  - Response: after 1 edge, rd_data_a=0xDEAD_BEEF, rd_data_b=0x1234, rd_valid=1.
- Zero register:
  - Stimulus: entry 31=0xFFFF, wr_en=1, wr_addr=31, wr_data=0xAAAA, read addr_a=31.
  - Response: rd_data_a=0.
  - Stimulus: repeat with ZERO_EN=0.
  - Response: rd_data_a=0xAAAA.
- Forwarding:
  - Stimulus: entry 3=0x11, wr_en=1, wr_addr=3, wr_data=0x77, addr_a=addr_b=3.
  - Response: both ports return 0x77.
  - Stimulus: wr_addr=4 instead.
  - Response: both ports return 0x11.
- Stall and hold:
  - Stimulus: capture 0x55 on port A, then stall=1 for 3 cycles with rd_en=1, addr_a changed, and `in` changed.
  - Response: rd_data_a stays 0x55 and rd_valid stays 1.
  - Stimulus: release stall with rd_en=0.
  - Response: rd_valid=0 and rd_data_a still 0x55.
- Out of range:
  - Stimulus: DEPTH=24, read addr_b=27.
  - Response: rd_data_b=0, addr_err=1.
  - Stimulus: next read with valid addresses.
  - Response: addr_err=0.
- Throughput and randomised check:
  - Stimulus: 1000 cycles of random rd_en, stall, addresses and writes.
  - Response: outputs match the reference model each cycle, one result per non-stalled rd_en.
